alu_cmd_issue: RTL and testbench
================================

Name: alu_cmd_issue

Overview:
- Command front end for the 8-bit ALU (`Alu_8bit`).
- Buffers ALU commands in a small FIFO using a valid/ready handshake.
- Issues one command at a time on registered ALU operand/operation outputs, then captures the ALU's combinational result and carry.
- Presents each result downstream with its own valid/ready handshake.
- Sits directly upstream of `Alu_8bit`, which consumes its `alu_*` outputs, and also holds that ALU's result register.

Parameters:
- WIDTH, 8: operand and result width in bits.
- DEPTH, 4: command FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command present.
- in_ready  output  1  FIFO can accept a command.
- in_op  input  2  operation: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=3.
- in_a  input  WIDTH  operand1.
- in_b  input  WIDTH  operand2.
- in_cin  input  1  operand3 (carry in).
- alu_op  output  2  to ALU `operation` (registered).
- alu_a  output  WIDTH  to ALU `operand1` (registered).
- alu_b  output  WIDTH  to ALU `operand2` (registered).
- alu_cin  output  1  to ALU `operand3` (registered).
- alu_result  input  WIDTH  from ALU `result`.
- alu_cout  input  1  from ALU `Cout`.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH  captured result.
- out_cout  output  1  captured carry.
- out_op  output  2  operation that produced the result.
- count  output  $clog2(DEPTH+1)  FIFO occupancy.
- busy  output  1  high when state != IDLE or count != 0.

Behaviour:
- Reset (rst high at a clock edge):
  - FIFO pointers and count cleared to 0; state goes to IDLE.
  - All `alu_*` outputs go to 0, so the ALU sees AND 0,0 with cin 0.
  - out_valid, out_result, out_cout, out_op all go to 0.
  - in_ready is 0 while rst is high and 1 on the first cycle after reset.
  - Reset mid-operation discards all queued, in-flight and held results, with no partial output.
- Push and FIFO:
  - A push happens when in_valid && in_ready. The command {op, a, b, cin} is written at wr_ptr.
  - in_ready = (count < DEPTH), computed combinationally from registered count.
  - When full, in_ready = 0 even if a pop occurs in the same cycle. There is no full-bypass.
  - Pointers are log2(DEPTH) bits wide and wrap naturally.
  - count increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
  - A push into an empty FIFO has no bypass: the entry is visible to the FSM on the next cycle.
- FSM, IDLE:
  - If count != 0, pop the head into the `alu_*` registers and go to EXEC.
  - Otherwise stay in IDLE; `alu_*` registers hold their values.
- FSM, EXEC:
  - The ALU settles combinationally during this cycle.
  - At the edge, capture alu_result, alu_cout and alu_op into the `out_*` registers, set out_valid = 1, and go to HOLD.
- FSM, HOLD:
  - out_valid = 1 and the `out_*` outputs are held stable until out_valid && out_ready.
  - On the handshake edge, if count != 0: pop the next command into `alu_*`, go to EXEC, and clear out_valid.
  - On the handshake edge, if count == 0: clear out_valid and go to IDLE.
- Latency and throughput:
  - With the FIFO empty and the block IDLE, a command accepted at edge E0 is popped at E1, and out_valid rises after E2.
  - With out_ready held high, sustained throughput is one result per 2 cycles.
- Capacity:
  - With out_ready held low, the block absorbs DEPTH+1 commands: one held in `out_*` and DEPTH in the FIFO.
- Ordering:
  - Results emerge strictly in acceptance order. Nothing is dropped or duplicated.
- Arithmetic:
  - The block performs no arithmetic; results come from the ALU.
  - The bench uses these expectations: AND = a&b; OR = a|b; ADD = a+b+cin (low WIDTH bits), with cout = the carry out of bit WIDTH-1; SUB with cin = 0 gives a−b (low WIDTH bits).
- in_op values: all 4 encodings are valid. There is no error path.

Test Plan:
- Reset, then idle 3 cycles → in_ready=1, out_valid=0, count=0, busy=0, all `alu_*` = 0.
- Push AND a=0xAA b=0xCC cin=0 at E0 with out_ready=1 → alu_a=0xAA and alu_b=0xCC after E1; out_valid high after E2 with out_result=0x88, out_op=0; handshake completes in that cycle.
- Back-to-back pushes with out_ready=1: OR 0xAA|0xCC, ADD 0x0F+0x01, ADD 0xFF+0x01 cin=1, SUB 0x0A−0x04 → results in order: 0xEE; 0x10 with cout 0; 0x01 with cout 1; 0x06; results spaced 2 cycles apart.
- out_ready=0, push continuously → exactly 5 commands accepted, in_ready=0, count=4; raise out_ready → all 5 results drain in order, and in_ready reasserts after the first pop.
- Push a command when count=4 while a pop occurs in the same cycle → push not accepted; count goes to 3; the command is accepted on the next cycle.
- Assert rst during EXEC with 3 entries queued → next cycle out_valid=0, count=0, state IDLE; no stale result appears afterwards.

Source files
------------

// File: rtl/alu_cmd_issue.sv
// -----------------------------------------------------------------------------
// alu_cmd_issue
//
// Command front end for the 8-bit ALU (Alu_8bit).
//
// The block buffers ALU commands in a small FIFO. It issues one command at a
// time on registered operand/operation outputs that drive the ALU directly.
// One cycle later it captures the ALU's combinational result and carry, and it
// presents that result downstream. The block also acts as the ALU's result
// register.
//
// Ports
//   clk, rst         single clock; synchronous active-high reset
//   in_valid/ready   command handshake; in_op/in_a/in_b/in_cin = command
//   alu_op/a/b/cin   registered operands to the ALU
//   alu_result/cout  combinational result from the ALU
//   out_valid/ready  result handshake; out_result/out_cout/out_op = result
//   count            FIFO occupancy
//   busy             state != IDLE or FIFO not empty
//   dbg_state        current FSM state (IDLE=0, EXEC=1, HOLD=2)
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready. A producer holds valid and its payload stable until the
// transfer. The ready signal may depend on registered state only. It never
// depends on the valid signal of the same interface.
// -----------------------------------------------------------------------------
module alu_cmd_issue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  // command input
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_op,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  input  logic                         in_cin,
  // ALU drive (registered)
  output logic [1:0]                   alu_op,
  output logic [WIDTH-1:0]             alu_a,
  output logic [WIDTH-1:0]             alu_b,
  output logic                         alu_cin,
  // ALU return (combinational in the ALU)
  input  logic [WIDTH-1:0]             alu_result,
  input  logic                         alu_cout,
  // result output
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_result,
  output logic                         out_cout,
  output logic [1:0]                   out_op,
  // status
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic [1:0]                   dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,   // ALU operands are stable; ALU settles this cycle
    S_HOLD = 2'd2    // result presented, waiting for downstream
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic [1:0]            r_mem_op  [DEPTH];
  logic [WIDTH-1:0]      r_mem_a   [DEPTH];
  logic [WIDTH-1:0]      r_mem_b   [DEPTH];
  logic                  r_mem_cin [DEPTH];

  logic [1:0]            r_alu_op;
  logic [WIDTH-1:0]      r_alu_a;
  logic [WIDTH-1:0]      r_alu_b;
  logic                  r_alu_cin;

  logic                  r_out_valid;
  logic [WIDTH-1:0]      r_out_result;
  logic                  r_out_cout;
  logic [1:0]            r_out_op;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  state_t                w_state_nxt;
  logic                  w_in_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_capture;
  logic                  w_release;
  logic                  w_fifo_nonempty;

  // Ready comes from the registered count only. A pop in the same cycle does
  // not free a slot for a push when the FIFO is full. This keeps in_ready off
  // the FSM decode path. It is also held low during reset.
  assign w_in_ready      = !rst && (r_count < FULL_CNT);
  assign w_push          = in_valid && w_in_ready;
  assign w_fifo_nonempty = (r_count != '0);

  // ---------------------------------------------------------------------------
  // Issue FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A push this cycle is seen only next cycle (there is no empty bypass).
        if (w_fifo_nonempty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          w_release = 1'b1;
          // Chain straight into the next command. This gives 2 cycles per
          // result when the downstream is always ready.
          if (w_fifo_nonempty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_EXEC;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage. There is no reset. Only slots that have been written are
  // ever read, because the count guards every pop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op[r_wr_ptr]  <= in_op;
      r_mem_a[r_wr_ptr]   <= in_a;
      r_mem_b[r_wr_ptr]   <= in_b;
      r_mem_cin[r_wr_ptr] <= in_cin;
    end
  end

  // FIFO pointers and occupancy. The pointers are log2(DEPTH) bits wide and
  // wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // ALU operand registers. After reset the ALU sees AND 0,0 with cin 0. The
  // registers hold their values between commands.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_op  <= 2'd0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_cin <= 1'b0;
    end else if (w_pop) begin
      r_alu_op  <= r_mem_op[r_rd_ptr];
      r_alu_a   <= r_mem_a[r_rd_ptr];
      r_alu_b   <= r_mem_b[r_rd_ptr];
      r_alu_cin <= r_mem_cin[r_rd_ptr];
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers. They capture at the end of EXEC and hold through HOLD.
  // The op is taken from the operand register, so it always matches the
  // result it belongs to.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_cout   <= 1'b0;
      r_out_op     <= 2'd0;
    end else if (w_capture) begin
      r_out_valid  <= 1'b1;
      r_out_result <= alu_result;
      r_out_cout   <= alu_cout;
      r_out_op     <= r_alu_op;
    end else if (w_release) begin
      r_out_valid  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready   = w_in_ready;
  assign alu_op     = r_alu_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_cin    = r_alu_cin;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_cout   = r_out_cout;
  assign out_op     = r_out_op;
  assign count      = r_count;
  assign busy       = (r_state != S_IDLE) || w_fifo_nonempty;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_issue: directed bench for alu_cmd_issue. The bench stands in for
// Alu_8bit with a small combinational model. It also checks every delivered
// result against a queue of hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_alu_cmd_issue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'd0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;
  logic [1:0]       out_op;
  logic [CW-1:0]    count;
  logic             busy;
  logic [1:0]       dbg_state;

  alu_cmd_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_cout(out_cout), .out_op(out_op),
    .count(count), .busy(busy), .dbg_state(dbg_state)
  );

  // Stand-in for Alu_8bit
  logic [WIDTH:0] alu_full;
  always_comb begin
    alu_full = '0;
    case (alu_op)
      2'd0: alu_full = {1'b0, alu_a & alu_b};
      2'd1: alu_full = {1'b0, alu_a | alu_b};
      2'd2: alu_full = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, alu_cin};
      default: alu_full = {1'b0, alu_a} - {1'b0, alu_b} - {{WIDTH{1'b0}}, alu_cin};
    endcase
  end
  assign alu_result = alu_full[WIDTH-1:0];
  assign alu_cout   = alu_full[WIDTH];

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected result word = {op, cout, result}
  logic [10:0] exp_q[$];
  int          hs_cyc[$];
  logic [10:0] mon_e;

  function automatic logic [10:0] pack(input logic [1:0] op, input logic co,
                                       input logic [7:0] res);
    return {op, co, res};
  endfunction

  // Scoreboard: every result handshake must match the head of exp_q.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL stale_result: observed=0x%0h expected=none",
               {out_op, out_cout, out_result});
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", {21'd0, out_op, out_cout, out_result}, {21'd0, mon_e});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic ci);
    in_op  = op;
    in_a   = a;
    in_b   = b;
    in_cin = ci;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_remaining", exp_q.size(), 0);
  endtask

  // Command table for the capacity test. The expectations are computed by hand.
  logic [1:0] t_op [6] = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd2, 2'd1};
  logic [7:0] t_a  [6] = '{8'h01, 8'hF0, 8'h0F, 8'h20, 8'h80, 8'h55};
  logic [7:0] t_b  [6] = '{8'h02, 8'h3C, 8'h30, 8'h01, 8'h80, 8'hAA};
  logic [10:0] t_exp[6] = '{{2'd2, 1'b0, 8'h03}, {2'd0, 1'b0, 8'h30},
                            {2'd1, 1'b0, 8'h3F}, {2'd3, 1'b0, 8'h1F},
                            {2'd2, 1'b1, 8'h00}, {2'd1, 1'b0, 8'hFF}};

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int acc;
    int d;

    // ---- reset and idle
    tick();
    tick();
    chk("in_ready_in_reset", in_ready, 0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_alu", {alu_op, alu_a, alu_b, alu_cin}, 0);
    chk("rst_out", {out_op, out_cout, out_result}, 0);

    // ---- single AND, latency
    out_ready = 1'b1;
    set_cmd(2'd0, 8'hAA, 8'hCC, 1'b0);
    in_valid = 1'b1;
    chk("lat_in_ready", in_ready, 1);
    exp_q.push_back(pack(2'd0, 1'b0, 8'h88));
    tick();                                   // E0: push
    in_valid = 1'b0;
    chk("lat_e0_count", count, 1);
    chk("lat_e0_out_valid", out_valid, 0);
    tick();                                   // E1: pop
    chk("lat_e1_alu_a", alu_a, 8'hAA);
    chk("lat_e1_alu_b", alu_b, 8'hCC);
    chk("lat_e1_out_valid", out_valid, 0);
    tick();                                   // E2: capture
    chk("lat_e2_out_valid", out_valid, 1);
    chk("lat_e2_result", out_result, 8'h88);
    chk("lat_e2_op", out_op, 0);
    tick();                                   // handshake
    chk("lat_after_hs_valid", out_valid, 0);
    chk("lat_after_hs_busy", busy, 0);
    chk("lat_queue_empty", exp_q.size(), 0);

    // ---- back-to-back, sustained throughput
    hs_cyc.delete();
    set_cmd(2'd1, 8'hAA, 8'hCC, 1'b0); in_valid = 1'b1;
    exp_q.push_back(pack(2'd1, 1'b0, 8'hEE));
    chk("b2b_ready0", in_ready, 1);
    tick();
    set_cmd(2'd2, 8'h0F, 8'h01, 1'b0);
    exp_q.push_back(pack(2'd2, 1'b0, 8'h10));
    chk("b2b_ready1", in_ready, 1);
    tick();
    set_cmd(2'd2, 8'hFF, 8'h01, 1'b1);
    exp_q.push_back(pack(2'd2, 1'b1, 8'h01));
    chk("b2b_ready2", in_ready, 1);
    tick();
    set_cmd(2'd3, 8'h0A, 8'h04, 1'b0);
    exp_q.push_back(pack(2'd3, 1'b0, 8'h06));
    chk("b2b_ready3", in_ready, 1);
    tick();
    in_valid = 1'b0;
    wait_drain(40);
    chk("b2b_results", hs_cyc.size(), 4);
    for (int i = 1; i < hs_cyc.size(); i++) begin
      chk("b2b_spacing", hs_cyc[i] - hs_cyc[i-1], 2);
    end
    tick();
    chk("b2b_idle_busy", busy, 0);

    // ---- capacity with out_ready low
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      set_cmd(t_op[acc], t_a[acc], t_b[acc], 1'b0);
      in_valid = (acc < 5);
      if (in_valid && in_ready) begin
        exp_q.push_back(t_exp[acc]);
        acc++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("cap_accepted", acc, 5);
    chk("cap_in_ready", in_ready, 0);
    chk("cap_count", count, 4);
    chk("cap_state_hold", dbg_state, 2);
    chk("cap_out_valid", out_valid, 1);

    // ---- full FIFO: push offered while a pop happens in the same cycle
    set_cmd(t_op[5], t_a[5], t_b[5], 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk("full_pop_in_ready", in_ready, 0);
    tick();                                   // pop only
    chk("full_pop_count", count, 3);
    chk("full_pop_ready_back", in_ready, 1);
    exp_q.push_back(t_exp[5]);
    tick();                                   // push accepted
    in_valid = 1'b0;
    chk("full_push_count", count, 4);
    wait_drain(80);
    tick();
    chk("cap_drain_busy", busy, 0);

    // ---- reset during EXEC with 3 queued
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      set_cmd(2'd2, 8'h10 + 8'(acc), 8'h20, 1'b0);
      in_valid = (acc < 5);
      if (in_valid && in_ready) begin
        exp_q.push_back(pack(2'd2, 1'b0, 8'h30 + 8'(acc)));
        acc++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("rx_accepted", acc, 5);
    out_ready = 1'b1;
    tick();                                   // first result handshakes
    chk("rx_state_exec", dbg_state, 1);
    chk("rx_count", count, 3);
    rst = 1'b1;
    exp_q.delete();                           // everything still in flight is discarded
    tick();
    chk("rx_in_ready_rst", in_ready, 0);
    rst = 1'b0;
    chk("rx_out_valid", out_valid, 0);
    chk("rx_count0", count, 0);
    chk("rx_state_idle", dbg_state, 0);
    chk("rx_alu", {alu_op, alu_a, alu_b, alu_cin}, 0);
    d = 0;
    repeat (12) begin
      tick();
      if (out_valid) d++;
    end
    chk("rx_no_stale", d, 0);
    chk("rx_in_ready_after", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
